// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
//
// Shared definitions for the sequential 8:3 priority encoder:
//   N           number of request lines (input word width)
//   W           index width, equal to clog2(N)
//   DROP_CNT_W  width of the saturating all-zero word counter
//   state_t     FSM states: IDLE accepts a word, DRAIN emits its indices
//   is_one_hot  true when exactly one bit of a word is set; used to flag
//               the final beat of a word
// ---------------------------------------------------------------------------
package enc_pkg;

  localparam int N          = 8;
  localparam int W          = 3;
  localparam int DROP_CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Counting every bit keeps the helper width-agnostic, and it avoids the
  // v & (v - 1) trick, which needs sized-arithmetic care.
  function automatic logic is_one_hot(input logic [N-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + int'(v[i]);
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/pe_find8.sv
// ---------------------------------------------------------------------------
// pe_find8
//
// Purely combinational N-bit find-first-set.
//
// Ports:
//   vec        input  N  word to search
//   msb_first  input  1  0: report the lowest set bit, 1: the highest
//   idx        output W  index of the selected set bit (0 when vec == 0)
//   found      output 1  vec has at least one bit set
// ---------------------------------------------------------------------------
module pe_find8
  import enc_pkg::*;
(
  input  logic [N-1:0] vec,
  input  logic         msb_first,
  output logic [W-1:0] idx,
  output logic         found
);

  // Priority is expressed by scan order: the last matching assignment in
  // the loop wins. To get the lowest set bit, scan downward so that bit 0
  // is visited last. To get the highest set bit, scan upward.
  always_comb begin
    idx   = '0;
    found = |vec;
    if (msb_first) begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) begin
          idx = W'(i);
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx = W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/seq_encoder_8to3.sv
// ---------------------------------------------------------------------------
// seq_encoder_8to3
//
// Sequential 8:3 priority encoder. A multi-hot request word is accepted
// over a valid/ready handshake. The block then emits the index of every
// set bit, one per output beat, and marks the final beat of the word with
// out_last. An all-zero word is swallowed and counted in drop_cnt, which
// saturates instead of wrapping.
//
// Build option:
//   ENC_MSB_FIRST_EN  when defined, indices are emitted highest first
//                     instead of lowest first. Ports and timing are the
//                     same in both builds.
//
// Ports:
//   clk        input   1           rising-edge clock
//   rst_n      input   1           synchronous active-low reset
//   in_valid   input   1           input word valid
//   in_ready   output  1           block can accept a word (state IDLE)
//   in_bits    input   N           multi-hot request word
//   out_valid  output  1           out_idx is valid
//   out_ready  input   1           consumer takes the current beat
//   out_idx    output  W           index of the current set bit
//   out_last   output  1           current beat is the last of the word
//   busy       output  1           a word is being drained
//   drop_cnt   output  DROP_CNT_W  saturating count of zero words
// ---------------------------------------------------------------------------
module seq_encoder_8to3
  import enc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_bits,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

`ifdef ENC_MSB_FIRST_EN
  localparam logic MSB_FIRST = 1'b1;
`else
  localparam logic MSB_FIRST = 1'b0;
`endif

  localparam logic [N-1:0]          ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  state_t                  state_q, state_d;
  logic [N-1:0]            pending_q, pending_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [W-1:0]            find_idx;
  logic                    find_found;
  logic [N-1:0]            sel_mask;
  logic                    last_bit;
  logic                    accept;
  logic                    fire;

  // The finder always looks at the pending word. In IDLE, pending is zero,
  // so the finder reports index 0 and found = 0.
  pe_find8 u_find (
    .vec       (pending_q),
    .msb_first (MSB_FIRST),
    .idx       (find_idx),
    .found     (find_found)
  );

  // The handshake-facing outputs are derived only from state and pending.
  // in_ready does not look at in_valid, so an upstream valid cannot form a
  // combinational loop through this block.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == DRAIN);
    out_valid = (state_q == DRAIN);
    last_bit  = is_one_hot(pending_q);
    out_idx   = (state_q == DRAIN) ? find_idx : '0;
    out_last  = (state_q == DRAIN) && last_bit;
    drop_cnt  = drop_cnt_q;
  end

  always_comb begin
    accept   = in_valid && in_ready;
    fire     = out_valid && out_ready;
    sel_mask = ONE_N << find_idx;
  end

  // Next-state logic. In IDLE, a nonzero word is loaded and drained.
  // A zero word only bumps the drop counter. In DRAIN, each fired beat
  // clears the bit it reported. The beat flagged as last returns the block
  // to IDLE with pending explicitly zeroed. If pending is ever empty while
  // in DRAIN, the FSM also falls back to IDLE, so it cannot get stuck
  // presenting a valid beat that has no set bit behind it.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    drop_cnt_d = drop_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_bits != '0) begin
            pending_d = in_bits;
            state_d   = DRAIN;
          end else if (drop_cnt_q != DROP_MAX) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
          end
        end
      end

      DRAIN: begin
        if (!find_found) begin
          pending_d = '0;
          state_d   = IDLE;
        end else if (fire) begin
          if (last_bit) begin
            pending_d = '0;
            state_d   = IDLE;
          end else begin
            pending_d = pending_q & ~sel_mask;
          end
        end
      end

      default: begin
        pending_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // Reset is synchronous, so a reset cycle that arrives during DRAIN throws
  // away whatever is still pending. No further beats are emitted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_encoder_8to3.sv
// ---------------------------------------------------------------------------
// tb_seq_encoder_8to3
//
// Self-checking bench for seq_encoder_8to3. Inputs change on the falling
// edge and outputs are sampled there. The expected index sequence of each
// word is built from its set bits with plain arithmetic, and the reference
// model consumes one entry per accepted beat.
// ---------------------------------------------------------------------------
module tb_seq_encoder_8to3;

  localparam int N      = 8;
  localparam int W      = 3;
  localparam int DW     = 8;
  localparam int BUDGET = 64;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_bits;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_idx;
  logic          out_last;
  logic          busy;
  logic [DW-1:0] drop_cnt;

  int total;
  int bad;
  int drops_model;

  seq_encoder_8to3 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected emission order: the positions of the set bits in ascending
  // order, reversed when the build emits the highest bit first.
  function automatic void build_expected(input logic [N-1:0] word, output int q[$]);
    q = {};
    for (int i = 0; i < N; i++) begin
      if (((int'(word) >> i) % 2) == 1) begin
`ifdef ENC_MSB_FIRST_EN
        q.push_front(i);
`else
        q.push_back(i);
`endif
      end
    end
  endfunction

  // Sends one word and follows it through to completion.
  // ready_mode 0: out_ready held high.
  // ready_mode 1: out_ready follows the pattern 1,0,0,1,0,0,...
  // ready_mode 2: out_ready is random.
  // While the word drains, in_valid and in_bits are random, because the
  // block must ignore them while it is busy.
  task automatic drive_word(input logic [N-1:0] word, input int ready_mode);
    int   q[$];
    int   cycles;
    logic rdy;
    logic exp_last;
    build_expected(word, q);

    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_before_word: in_ready=%b required 1", in_ready);
    end
    in_valid  = 1'b1;
    in_bits   = word;
    out_ready = 1'b0;
    if (word == '0 && drops_model < 255) drops_model++;

    @(negedge clk);
    in_valid = 1'($urandom);
    in_bits  = N'($urandom);
    cycles   = 0;
    while (q.size() > 0 && cycles < BUDGET) begin
      exp_last = (q.size() == 1);
      total++;
      if (out_valid !== 1'b1 || out_idx !== W'(q[0]) || out_last !== exp_last ||
          busy !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL beat word=%h: valid=%b idx=%0d last=%b busy=%b rdy=%b required valid=1 idx=%0d last=%b busy=1 rdy=0",
                 word, out_valid, out_idx, out_last, busy, in_ready, q[0], exp_last);
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cycles % 3 == 0);
        default: rdy = 1'($urandom);
      endcase
      out_ready = rdy;
      if (rdy) void'(q.pop_front());
      cycles++;
      @(negedge clk);
      in_valid = 1'($urandom);
      in_bits  = N'($urandom);
    end
    in_valid = 1'b0;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout word=%h: %0d beats left, required 0", word, q.size());
    end

    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || drop_cnt !== DW'(drops_model)) begin
      bad++;
      $display("[TB] FAIL after_word %h: valid=%b rdy=%b busy=%b drop=%0d required 0 1 0 %0d",
               word, out_valid, in_ready, busy, drop_cnt, drops_model);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_bits   = 8'hFF;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    drops_model = 0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'd0 ||
        out_idx !== 3'd0 || out_last !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state: valid=%b busy=%b drop=%0d idx=%0d last=%b required all 0",
               out_valid, busy, drop_cnt, out_idx, out_last);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_one_hot();
    drive_word(8'b0010_0000, 0);
    for (int i = 0; i < N; i++) drive_word(N'(1) << i, 0);
  endtask

  task automatic test_multi_hot();
    drive_word(8'b1001_0110, 0);
    drive_word(8'b1000_0001, 0);
  endtask

  task automatic test_stall();
    drive_word(8'hFF, 1);
    drive_word(8'b0101_1010, 1);
  endtask

  task automatic test_zero_words();
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || drop_cnt !== DW'(drops_model)) begin
        bad++;
        $display("[TB] FAIL zero_word %0d: valid=%b rdy=%b drop=%0d required 0 1 %0d",
                 i, out_valid, in_ready, drop_cnt, drops_model);
      end
      in_valid = 1'b1;
      in_bits  = '0;
      if (drops_model < 255) drops_model++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (drop_cnt !== 8'd255 || out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drop_saturate: drop=%0d valid=%b required 255 0", drop_cnt, out_valid);
    end
  endtask

  task automatic test_reset_mid_drain();
    int q[$];
    build_expected(8'b0000_1100, q);
    @(negedge clk);
    in_valid  = 1'b1;
    in_bits   = 8'b0000_1100;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_idx !== W'(q[0]) || out_last !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_first_beat: valid=%b idx=%0d last=%b required 1 %0d 0",
               out_valid, out_idx, out_last, q[0]);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_idx !== W'(q[1]) || out_last !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_second_pending: valid=%b idx=%0d last=%b required 1 %0d 1",
               out_valid, out_idx, out_last, q[1]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n       = 1'b1;
    drops_model = 0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || drop_cnt !== 8'd0) begin
        bad++;
        $display("[TB] FAIL mid_reset_clear %0d: valid=%b busy=%b rdy=%b drop=%0d required 0 0 1 0",
                 i, out_valid, busy, in_ready, drop_cnt);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    drive_word(8'b0100_0100, 0);
  endtask

  task automatic test_random();
    logic [N-1:0] w;
    for (int i = 0; i < 40; i++) begin
      w = N'($urandom);
      if (i % 7 == 3) w = '0;
      drive_word(w, 2);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    drops_model = 0;
    rst_n       = 1'b1;
    in_valid    = 1'b0;
    in_bits     = '0;
    out_ready   = 1'b0;

    test_reset();
    test_one_hot();
    test_multi_hot();
    test_stall();
    test_zero_words();
    test_reset_mid_drain();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_encoder_8to3.md
Name: seq_encoder_8to3

Overview:
- Sequential 8:3 priority encoder; the inverse path of the team's 3:8 decoder.
- Accepts an 8-bit multi-hot request word over a valid/ready handshake.
- Emits the 3-bit index of every set bit, one index per handshake beat, lowest index first, and flags the final beat of each word.
- Sits between request-collection logic and any downstream consumer of binary indices, such as decoder-driven select logic.

Parameters:
- N, 8, input word width (number of request lines).
- W, 3, index width; must equal clog2(N).
- DROP_CNT_W, 8, width of the saturating zero-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word.
- in_bits  input  N  multi-hot request word.
- out_valid  output  1  out_idx valid.
- out_ready  input  1  consumer accepts the current beat.
- out_idx  output  W  index of the current set bit.
- out_last  output  1  current beat is the last set bit of the word.
- busy  output  1  a word is held in the block (state DRAIN).
- drop_cnt  output  DROP_CNT_W  saturating count of all-zero words accepted.

Behaviour:
- Reset: sampled on posedge clk while rst_n==0. All outputs and internal state reset as follows:
  - state=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, busy=0, drop_cnt=0.
  - in_ready=1 in the first cycle after reset release.
- Reset mid-DRAIN discards the pending word; no further beats are emitted.
- States: IDLE, DRAIN.
- in_ready = (state==IDLE). This output is combinational from state only and has no dependence on in_valid.
- IDLE, on in_valid&&in_ready:
  - in_bits!=0: pending<=in_bits, state<=DRAIN. The first out_valid appears the next cycle (latency 1).
  - in_bits==0: the word is discarded, drop_cnt increments (saturates at all-ones, no wrap), and the block stays in IDLE.
- DRAIN behaviour:
  - out_valid=1.
  - out_idx = index of the lowest set bit of pending.
  - out_last = (pending has exactly one bit set).
  - All three are combinational from pending.
- Beat fires on out_valid&&out_ready: that bit is cleared in pending. If out_last was 1, state<=IDLE, pending<=0 and in_ready=1 the next cycle.
- Stall (out_ready=0): pending, out_idx and out_last hold stable. out_valid never drops without a fire.
- Beat count per word = popcount(in_bits), range 1..N. in_bits=8'hFF takes 8 beats; a one-hot word takes exactly 1 beat with out_last=1.
- Throughput: 1 index/cycle with out_ready held high. There is one IDLE bubble cycle between words; no overlap of acceptance and draining.
- in_bits is ignored outside an accepting handshake.

Optional Feature:
- Macro: ENC_MSB_FIRST_EN.
- Defined: out_idx = highest set bit of pending, so indices are emitted in descending order. out_last still marks the single remaining bit.
- Undefined (default): lowest set bit first, as specified above.
- No port or timing differences between the two builds.

Decomposition:
- Package enc_pkg holds:
  - constants N=8, W=3, DROP_CNT_W=8;
  - the state typedef {IDLE, DRAIN};
  - a popcount-is-one helper function.
- One sub-module: pe_find8, a purely combinational N-bit find-first-set. Inputs: pending and a direction select tied from ENC_MSB_FIRST_EN. Outputs: W-bit index and a found flag.
- The top level holds the FSM, the pending register and drop_cnt.

Test Plan:
1. Reset with rst_n=0 for 2 cycles while in_valid=1 and in_bits=8'hFF. Required: out_valid=0, busy=0, drop_cnt=0; in_ready=1 on the first cycle after release.
2. Send in_bits=8'b0010_0000 with out_ready=1. Required: one beat next cycle with out_idx=5, out_last=1; in_ready=1 the cycle after.
3. Send in_bits=8'b1001_0110 with out_ready=1. Required: beats 1,2,4,7 on consecutive cycles, out_last only on idx 7. With ENC_MSB_FIRST_EN defined, the order is 7,4,2,1 with out_last on 1.
4. Send in_bits=8'hFF while toggling out_ready 1,0,0,1,... Required: out_idx and out_last stable through stalls; exactly 8 beats, 0..7.
5. Send 300 consecutive zero words. Required: no out_valid; drop_cnt saturates at 255; in_ready stays 1.
6. Send 8'b0000_1100, take 1 beat (idx 2), then assert rst_n=0 for 1 cycle. Required: pending cleared; idx 3 is never emitted; a new word is accepted normally afterwards.
